// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared encodings and frame builder for the PCF8574 LCD byte writer.
// Revision : 1.0
// ============================================================================
package lcd_pkg;

    localparam int c_cnt_w = 11;

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_send     = 3'd1;
    localparam logic [2:0] c_st_wait_ack = 3'd2;
    localparam logic [2:0] c_st_settle   = 3'd3;
    localparam logic [2:0] c_st_done     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = c_st_idle,
        ST_SEND     = c_st_send,
        ST_WAIT_ACK = c_st_wait_ack,
        ST_SETTLE   = c_st_settle,
        ST_DONE     = c_st_done
    } state_t;

    // Expander pin positions P0..P7
    localparam int c_bit_rs = 0;
    localparam int c_bit_rw = 1;
    localparam int c_bit_en = 2;
    localparam int c_bit_bl = 3;
    localparam int c_bit_d4 = 4;
    localparam int c_bit_d7 = 7;

    localparam logic [7:0] c_cmd_clear = 8'h01;
    localparam logic [7:0] c_cmd_home  = 8'h02;

    function automatic logic [7:0] build_frame(
        input logic [3:0] nibble,
        input logic       bl,
        input logic       en,
        input logic       rs
    );
        logic [7:0] frame;
        frame                     = 8'h00;
        frame[c_bit_d7:c_bit_d4]  = nibble;
        frame[c_bit_bl]           = bl;
        frame[c_bit_en]           = en;
        frame[c_bit_rw]           = 1'b0;
        frame[c_bit_rs]           = rs;
        return frame;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_byte_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_byte_writer
// Purpose  : Sends one HD44780 byte as four 4-bit-mode PCF8574 frames, then settles.
// Revision : 1.0
// ============================================================================
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int SHORT_WAIT = 40,
    parameter int LONG_WAIT  = 2000
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic       ena_write,
    input  logic [7:0] data,
    input  logic       cmd_data,
    input  logic       backlight,
    output logic       done_write,
    output logic       busy,
    output logic       err,
    output logic [7:0] exp_data,
    output logic       exp_valid,
    input  logic       exp_done,
    input  logic       exp_nack
);

    localparam logic [c_cnt_w-1:0] c_short_last = c_cnt_w'(SHORT_WAIT - 1);
    localparam logic [c_cnt_w-1:0] c_long_last  = c_cnt_w'(LONG_WAIT - 1);

    state_t             r_state_q,    w_state_d;
    logic [1:0]         r_idx_q,      w_idx_d;
    logic [c_cnt_w-1:0] r_cnt_q,      w_cnt_d;
    logic [7:0]         r_data_q,     w_data_d;
    logic               r_cmd_data_q, w_cmd_data_d;
    logic               r_bl_q,       w_bl_d;
    logic               r_err_q,      w_err_d;
    logic [7:0]         r_exp_data_q, w_exp_data_d;

    logic               w_long;
    logic               w_settle_last;

    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_cnt_d       = r_cnt_q;
        w_data_d      = r_data_q;
        w_cmd_data_d  = r_cmd_data_q;
        w_bl_d        = r_bl_q;
        w_err_d       = r_err_q;
        w_exp_data_d  = r_exp_data_q;

        w_long        = !r_cmd_data_q && (r_data_q == c_cmd_clear || r_data_q == c_cmd_home);
        w_settle_last = w_long ? (r_cnt_q == c_long_last) : (r_cnt_q == c_short_last);

        case (r_state_q)
            ST_IDLE: begin
                if (ena_write) begin
                    w_data_d     = data;
                    w_cmd_data_d = cmd_data;
                    w_bl_d       = backlight;
                    w_err_d      = 1'b0;
                    w_idx_d      = 2'd0;
                    w_state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                w_state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (exp_done) begin
                    if (exp_nack) begin
                        w_err_d   = 1'b1;
                        w_state_d = ST_DONE;
                    end else if (r_idx_q == 2'd3) begin
                        w_cnt_d   = '0;
                        w_state_d = ST_SETTLE;
                    end else begin
                        w_idx_d   = r_idx_q + 2'd1;
                        w_state_d = ST_SEND;
                    end
                end
            end
            ST_SETTLE: begin
                if (w_settle_last) begin
                    w_state_d = ST_DONE;
                end else if (r_cnt_q != '1) begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Frame is registered on entry to SEND so it is stable for the whole I2C transfer.
        if (w_state_d == ST_SEND) begin
            w_exp_data_d = build_frame(w_idx_d[1] ? w_data_d[3:0] : w_data_d[7:4],
                                       w_bl_d, ~w_idx_d[0], w_cmd_data_d);
        end
    end

    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_idx_q      <= 2'd0;
            r_cnt_q      <= '0;
            r_data_q     <= 8'h00;
            r_cmd_data_q <= 1'b0;
            r_bl_q       <= 1'b0;
            r_err_q      <= 1'b0;
            r_exp_data_q <= 8'h00;
        end else begin
            r_state_q    <= w_state_d;
            r_idx_q      <= w_idx_d;
            r_cnt_q      <= w_cnt_d;
            r_data_q     <= w_data_d;
            r_cmd_data_q <= w_cmd_data_d;
            r_bl_q       <= w_bl_d;
            r_err_q      <= w_err_d;
            r_exp_data_q <= w_exp_data_d;
        end
    end

    assign busy       = (r_state_q != ST_IDLE);
    assign exp_valid  = (r_state_q == ST_SEND);
    assign done_write = (r_state_q == ST_DONE);
    assign err        = r_err_q;
    assign exp_data   = r_exp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_byte_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_byte_writer
// Purpose  : Randomized self-checking bench for lcd_byte_writer with a frame/timing model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_byte_writer;

    logic       clk_1MHz = 1'b0;
    logic       rst       = 1'b1;
    logic       ena_write = 1'b0;
    logic [7:0] data      = 8'h00;
    logic       cmd_data  = 1'b0;
    logic       backlight = 1'b0;
    logic       exp_done  = 1'b0;
    logic       exp_nack  = 1'b0;
    logic       done_write;
    logic       busy;
    logic       err;
    logic [7:0] exp_data;
    logic       exp_valid;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_byte_writer #(.SHORT_WAIT(40), .LONG_WAIT(2000)) u_dut (
        .clk_1MHz   (clk_1MHz),
        .rst        (rst),
        .ena_write  (ena_write),
        .data       (data),
        .cmd_data   (cmd_data),
        .backlight  (backlight),
        .done_write (done_write),
        .busy       (busy),
        .err        (err),
        .exp_data   (exp_data),
        .exp_valid  (exp_valid),
        .exp_done   (exp_done),
        .exp_nack   (exp_nack)
    );

    always #500 clk_1MHz = ~clk_1MHz;

    task automatic tick;
        @(posedge clk_1MHz);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame f: 0/1 = high nibble EN high/low, 2/3 = low nibble EN high/low
    function automatic logic [7:0] model_frame(input int d, input int bl, input int rs, input int f);
        int nib;
        int en;
        nib = (f < 2) ? (d / 16) : (d % 16);
        en  = (f % 2 == 0) ? 1 : 0;
        return 8'(nib * 16 + bl * 8 + en * 4 + rs);
    endfunction

    function automatic int model_wait(input int d, input int cd);
        return (cd == 0 && (d == 1 || d == 2)) ? 2000 : 40;
    endfunction

    task automatic run_byte(input logic [7:0] d, input logic cd, input logic bl,
                            input int nack_at, input bit noise);
        logic [7:0] exp_f;
        int         n;
        int         extra_valid;
        bit         aborted;
        aborted   = 1'b0;
        data      = d;
        cmd_data  = cd;
        backlight = bl;
        ena_write = 1'b1;
        tick;
        ena_write = 1'b0;
        check_val("busy_on_accept", 32'(busy), 1);
        check_val("err_clear_on_accept", 32'(err), 0);
        for (int f = 0; f < 4 && !aborted; f++) begin
            n = 0;
            while (!exp_valid && n < 20) begin
                tick;
                n++;
            end
            check_val("exp_valid_seen", 32'(exp_valid), 1);
            exp_f = model_frame(int'(d), int'(bl), int'(cd), f);
            check_val($sformatf("frame%0d", f), 32'(exp_data), 32'(exp_f));
            tick;
            check_val("exp_valid_single", 32'(exp_valid), 0);
            repeat ($urandom_range(0, 4)) begin
                if (noise) begin
                    ena_write = 1'b1;
                    data      = 8'($urandom);
                    cmd_data  = 1'($urandom_range(0, 1));
                    backlight = 1'($urandom_range(0, 1));
                end
                tick;
                ena_write = 1'b0;
            end
            check_val("frame_hold", 32'(exp_data), 32'(exp_f));
            exp_done = 1'b1;
            exp_nack = (f == nack_at);
            tick;
            exp_done = 1'b0;
            exp_nack = 1'b0;
            if (f == nack_at) aborted = 1'b1;
        end
        if (aborted) begin
            check_val("nack_done", 32'(done_write), 1);
            check_val("nack_err", 32'(err), 1);
        end else begin
            n           = 1;
            extra_valid = 0;
            while (!done_write && n < 3000) begin
                if (noise) exp_done = 1'($urandom_range(0, 1));
                tick;
                n++;
                if (exp_valid) extra_valid++;
            end
            exp_done = 1'b0;
            check_val("settle_cycles", n, model_wait(int'(d), int'(cd)) + 1);
            check_val("no_valid_in_settle", extra_valid, 0);
            check_val("err_after_ok", 32'(err), 0);
        end
        if (noise) begin
            ena_write = 1'b1;
            data      = 8'($urandom);
        end
        tick;
        ena_write = 1'b0;
        check_val("done_single", 32'(done_write), 0);
        check_val("idle_after_done", 32'(busy), 0);
        check_val("no_valid_after_done", 32'(exp_valid), 0);
        check_val("err_held", 32'(err), aborted ? 1 : 0);
    endtask

    task automatic reset_in_wait_ack;
        int n;
        int seen;
        data      = 8'h5A;
        cmd_data  = 1'b1;
        backlight = 1'b1;
        ena_write = 1'b1;
        tick;
        ena_write = 1'b0;
        n = 0;
        while (!exp_valid && n < 20) begin
            tick;
            n++;
        end
        tick;
        rst = 1'b1;
        tick;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done_write), 0);
        check_val("rst_valid", 32'(exp_valid), 0);
        check_val("rst_err", 32'(err), 0);
        check_val("rst_exp_data", 32'(exp_data), 0);
        rst      = 1'b0;
        exp_done = 1'b1;
        tick;
        exp_done = 1'b0;
        seen = 0;
        repeat (10) begin
            tick;
            if (exp_valid || done_write || busy) seen++;
        end
        check_val("rst_late_exp_done_ignored", seen, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic       cd;
        int         nack_at;
        repeat (3) tick;
        check_val("reset_busy", 32'(busy), 0);
        check_val("reset_done", 32'(done_write), 0);
        check_val("reset_err", 32'(err), 0);
        check_val("reset_valid", 32'(exp_valid), 0);
        check_val("reset_exp_data", 32'(exp_data), 0);
        rst = 1'b0;
        tick;

        run_byte(8'h28, 1'b0, 1'b1, -1, 1'b0);
        run_byte(8'h41, 1'b1, 1'b1, -1, 1'b0);
        run_byte(8'h01, 1'b0, 1'b0, -1, 1'b0);
        run_byte(8'h02, 1'b1, 1'b1, -1, 1'b1);
        run_byte(8'h9C, 1'b1, 1'b1,  1, 1'b1);
        run_byte(8'h33, 1'b0, 1'b1, -1, 1'b1);
        run_byte(8'h77, 1'b1, 1'b0,  3, 1'b0);
        reset_in_wait_ack;

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                d  = 8'($urandom_range(1, 2));
                cd = 1'b0;
            end else begin
                d  = 8'($urandom);
                cd = 1'($urandom_range(0, 1));
            end
            nack_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_byte(d, cd, 1'($urandom_range(0, 1)), nack_at, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_byte_writer.md
LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; all state SHALL update on posedge clk_1MHz only.
REQ-002 Parameter SHORT_WAIT, default 40: settle cycles after an ordinary byte.
REQ-003 Parameter LONG_WAIT, default 2000: settle cycles after a clear (0x01) or home (0x02) command.
REQ-004 Ports SHALL be exactly:
- clk_1MHz  in  1  1 MHz system clock
- rst  in  1  synchronous active-high reset
- ena_write  in  1  single-cycle request to write one LCD byte
- data  in  8  LCD byte
- cmd_data  in  1  0 = command (RS=0), 1 = character data (RS=1)
- backlight  in  1  value driven on expander bit P3
- done_write  out  1  single-cycle pulse when the byte is complete and settled
- busy  out  1  high from acceptance through the done_write cycle
- err  out  1  last byte aborted by an expander NACK; held until the next accepted request
- exp_data  out  8  PCF8574 output byte for the I2C master
- exp_valid  out  1  single-cycle request to the I2C master to send exp_data
- exp_done  in  1  single-cycle pulse from the I2C master: frame finished
- exp_nack  in  1  qualifies exp_done: slave did not acknowledge

Function
REQ-005 Expander bit map: P7..P4 = LCD D7..D4, P3 = backlight, P2 = EN, P1 = RW (always 0), P0 = RS.
REQ-006 Each LCD byte SHALL be sent as exactly 4 frames, in this order:
- {hi nibble, BL, EN=1, 0, RS}
- {hi nibble, BL, EN=0, 0, RS}
- {lo nibble, BL, EN=1, 0, RS}
- {lo nibble, BL, EN=0, 0, RS}
REQ-007 States SHALL be IDLE, SEND, WAIT_ACK, SETTLE and DONE.
REQ-008 IDLE: on ena_write=1, latch data, cmd_data and backlight, clear err, reset frame index to 0 and go to SEND; busy rises on the next cycle.
REQ-009 SEND: drive exp_data for the current frame index, assert exp_valid for exactly this one cycle, then go to WAIT_ACK.
REQ-010 WAIT_ACK: on exp_done with exp_nack=0, step as follows:
- frame index < 3: increment the index and go to SEND;
- frame index = 3: go to SETTLE.
REQ-011 WAIT_ACK: on exp_done with exp_nack=1, set err, send no further frames and go to DONE.
REQ-012 SETTLE: clear the counter on entry and go to DONE when it reaches W-1.
- W = LONG_WAIT if cmd_data=0 and data is 0x01 or 0x02.
- W = SHORT_WAIT otherwise.
REQ-013 DONE: assert done_write for exactly one cycle, then return to IDLE.
REQ-014 exp_data SHALL hold its value from SEND until the next SEND.
REQ-015 ena_write SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-016 exp_done SHALL be ignored outside WAIT_ACK.
REQ-017 The settle counter SHALL be 11 bits wide and saturate rather than wrap.
REQ-018 The block SHALL not time out internally while waiting for exp_done.

Reset
REQ-019 While rst=1, the following SHALL hold:
- state = IDLE, frame index = 0, counter = 0;
- done_write, busy, err, exp_valid = 0;
- exp_data = 0x00.
REQ-020 Reset during any state SHALL abandon the byte with no done_write pulse, and any exp_done arriving afterwards SHALL be ignored.

Structure
REQ-021 The shared package lcd_pkg SHALL hold:
- the state encoding;
- bit-position constants for P0..P7;
- the 0x01/0x02 long-command codes;
- a pure function that builds a frame from nibble, BL, EN and RS.
REQ-022 The block SHALL be a single module with no sub-modules.

Verification
REQ-023 Command data=0x28, cmd_data=0, BL=1 -> frames 0x2C, 0x28, 0x8C, 0x88; done_write 40 cycles after the 4th exp_done (+1 cycle for DONE).
REQ-024 Character data=0x41, cmd_data=1, BL=1 -> frames 0x4D, 0x49, 0x1D, 0x19; err=0.
REQ-025 Clear data=0x01, cmd_data=0, BL=0 -> frames 0x04, 0x00, 0x14, 0x10; done_write 2000 cycles after the 4th exp_done (+1 cycle for DONE).
REQ-026 exp_nack=1 on frame 2 -> no 3rd exp_valid; done_write pulses with err=1; err clears on the next accepted ena_write.
REQ-027 ena_write pulsed while busy=1 -> ignored, with frame count and data unchanged.
REQ-028 rst asserted in WAIT_ACK -> all outputs 0 next cycle; a later exp_done produces no exp_valid and no done_write.
